// File: rtl/uart_apb_cmd_master.sv
// uart_apb_cmd_master
// Turns byte-framed commands from a UART receive stream into single APB
// transfers and returns one response byte per frame on a transmit stream.
//   Write frame : 'W', addr, data  -> 'K' on success
//   Read frame  : 'R', addr        -> PRDATA on success
//   Slave error or unknown command -> 'E'
// A frame that stalls between bytes for TIMEOUT cycles is abandoned silently.

module uart_apb_cmd_master #(
   parameter int ADDR_W  = 5,
   parameter int TIMEOUT = 1000
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic [7:0]        RX_DATA,
   input  logic              RX_VALID,
   output logic [7:0]        TX_DATA,
   output logic              TX_VALID,
   input  logic              TX_READY,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [7:0]        PWDATA,
   input  logic [7:0]        PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   output logic              RX_DROP,
   output logic              BUSY
);

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h45;

   // Counter only has to reach TIMEOUT-1, so log2(TIMEOUT) bits suffice.
   localparam int              CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_ADDR,
      ST_GET_DATA,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t              state_reg;
   logic [CNT_W-1:0]    timer_reg;
   logic                dir_write_reg;
   logic [7:0]          tx_data_reg;
   logic                tx_valid_reg;
   logic [ADDR_W-1:0]   paddr_reg;
   logic                psel_reg;
   logic                penable_reg;
   logic                pwrite_reg;
   logic [7:0]          pwdata_reg;
   logic [ADDR_W-1:0]   addr_field;

   // Address taken from the low bits of the address byte; zero-padded
   // when the bus is wider than a byte.
   genvar gi;
   generate
      for (gi = 0; gi < ADDR_W; gi++) begin : g_addr
         if (gi < 8) begin : g_bit
            assign addr_field[gi] = RX_DATA[gi];
         end else begin : g_pad
            assign addr_field[gi] = 1'b0;
         end
      end
   endgenerate

   // Frame parser, APB sequencer and response holder with registered outputs.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_reg     <= ST_IDLE;
         timer_reg     <= '0;
         dir_write_reg <= 1'b0;
         tx_data_reg   <= 8'h00;
         tx_valid_reg  <= 1'b0;
         paddr_reg     <= '0;
         psel_reg      <= 1'b0;
         penable_reg   <= 1'b0;
         pwrite_reg    <= 1'b0;
         pwdata_reg    <= 8'h00;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (RX_VALID) begin
                  timer_reg <= '0;
                  if (RX_DATA == CMD_WRITE || RX_DATA == CMD_READ) begin
                     dir_write_reg <= (RX_DATA == CMD_WRITE);
                     state_reg     <= ST_GET_ADDR;
                  end else begin
                     tx_data_reg  <= RSP_ERR;
                     tx_valid_reg <= 1'b1;
                     state_reg    <= ST_RESP;
                  end
               end
            end

            ST_GET_ADDR: begin
               // An arriving byte wins over an expiring timer.
               if (RX_VALID) begin
                  timer_reg <= '0;
                  paddr_reg <= addr_field;
                  if (dir_write_reg) begin
                     state_reg <= ST_GET_DATA;
                  end else begin
                     pwrite_reg <= 1'b0;
                     psel_reg   <= 1'b1;
                     state_reg  <= ST_SETUP;
                  end
               end else if (timer_reg == CNT_LAST) begin
                  timer_reg <= '0;
                  state_reg <= ST_IDLE;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end

            ST_GET_DATA: begin
               if (RX_VALID) begin
                  timer_reg  <= '0;
                  pwdata_reg <= RX_DATA;
                  pwrite_reg <= 1'b1;
                  psel_reg   <= 1'b1;
                  state_reg  <= ST_SETUP;
               end else if (timer_reg == CNT_LAST) begin
                  timer_reg <= '0;
                  state_reg <= ST_IDLE;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end

            ST_SETUP: begin
               penable_reg <= 1'b1;
               state_reg   <= ST_ACCESS;
            end

            ST_ACCESS: begin
               if (PREADY) begin
                  psel_reg     <= 1'b0;
                  penable_reg  <= 1'b0;
                  tx_valid_reg <= 1'b1;
                  if (PSLVERR) begin
                     tx_data_reg <= RSP_ERR;
                  end else if (pwrite_reg) begin
                     tx_data_reg <= RSP_OK;
                  end else begin
                     tx_data_reg <= PRDATA;
                  end
                  state_reg <= ST_RESP;
               end
            end

            ST_RESP: begin
               if (TX_READY) begin
                  tx_valid_reg <= 1'b0;
                  state_reg    <= ST_IDLE;
               end
            end

            default: begin
               psel_reg     <= 1'b0;
               penable_reg  <= 1'b0;
               tx_valid_reg <= 1'b0;
               state_reg    <= ST_IDLE;
            end
         endcase
      end
   end

   assign TX_DATA  = tx_data_reg;
   assign TX_VALID = tx_valid_reg;
   assign PADDR    = paddr_reg;
   assign PSEL     = psel_reg;
   assign PENABLE  = penable_reg;
   assign PWRITE   = pwrite_reg;
   assign PWDATA   = pwdata_reg;

   // Bytes arriving while a transfer or response is in flight are lost;
   // flag them in the same cycle so the host side can notice.
   assign RX_DROP = RX_VALID && (state_reg == ST_SETUP  ||
                                 state_reg == ST_ACCESS ||
                                 state_reg == ST_RESP);
   assign BUSY    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_apb_cmd_master.sv
// Randomized bench for uart_apb_cmd_master. The bench plays the UART host,
// the TX consumer and a small APB memory slave. Expected responses come from
// a frame-level reference memory updated from the frames the bench sends.

module tb_uart_apb_cmd_master;

   localparam int ADDR_W  = 5;
   localparam int TIMEOUT = 8;

   logic              PCLK = 1'b0;
   logic              PRESETN;
   logic [7:0]        RX_DATA;
   logic              RX_VALID;
   logic [7:0]        TX_DATA;
   logic              TX_VALID;
   logic              TX_READY;
   logic [ADDR_W-1:0] PADDR;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [7:0]        PWDATA;
   logic [7:0]        PRDATA;
   logic              PREADY;
   logic              PSLVERR;
   logic              RX_DROP;
   logic              BUSY;

   int err_count   = 0;
   int check_count = 0;
   int frame_no    = 0;

   logic [7:0] ref_mem   [0:31];
   logic [7:0] slave_mem [0:31];

   uart_apb_cmd_master #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .PCLK     (PCLK),
      .PRESETN  (PRESETN),
      .RX_DATA  (RX_DATA),
      .RX_VALID (RX_VALID),
      .TX_DATA  (TX_DATA),
      .TX_VALID (TX_VALID),
      .TX_READY (TX_READY),
      .PADDR    (PADDR),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PWRITE   (PWRITE),
      .PWDATA   (PWDATA),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR),
      .RX_DROP  (RX_DROP),
      .BUSY     (BUSY)
   );

   always #5 PCLK = ~PCLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Start a new cycle: inputs driven 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge PCLK);
      #1;
   endtask

   // Idle for gap cycles, then strobe one byte; checked mid-cycle.
   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         cyc();
         RX_VALID = 1'b0;
         @(negedge PCLK);
         check_val("psel_gap", PSEL, 0);
      end
      cyc();
      RX_VALID = 1'b1;
      RX_DATA  = b;
      @(negedge PCLK);
      check_val("psel_rx", PSEL, 0);
      check_val("txv_rx", TX_VALID, 0);
      check_val("drop_rx", RX_DROP, 0);
   endtask

   // Wait out the response with hold cycles of backpressure, then accept it.
   task automatic take_resp(input logic [7:0] exp, input int hold, input string tag);
      for (int j = 0; j <= hold; j++) begin
         cyc();
         RX_VALID = 1'b0;
         TX_READY = (j == hold);
         @(negedge PCLK);
         check_val({tag, "_txv"}, TX_VALID, 1);
         check_val({tag, "_txd"}, TX_DATA, exp);
         check_val({tag, "_psel"}, PSEL, 0);
      end
      cyc();
      TX_READY = 1'b0;
      @(negedge PCLK);
      check_val({tag, "_txv_done"}, TX_VALID, 0);
      check_val({tag, "_busy_done"}, BUSY, 0);
   endtask

   // One complete read or write frame through APB to the response.
   task automatic do_frame(input bit is_write, input logic [7:0] addr, input logic [7:0] data,
                           input int waits, input bit err, input int hold,
                           input bit drop, input int gap);
      logic [7:0] exp_rsp;
      logic [4:0] a;
      a = addr[4:0];
      if (err)           exp_rsp = 8'h45;
      else if (is_write) exp_rsp = 8'h4B;
      else               exp_rsp = ref_mem[a];
      if (is_write && !err) ref_mem[a] = data;

      send_byte(is_write ? 8'h57 : 8'h52, 0);
      send_byte(addr, gap);
      if (is_write) send_byte(data, gap);

      // SETUP
      cyc();
      RX_VALID = 1'b0;
      PREADY   = 1'b0;
      @(negedge PCLK);
      check_val("setup_psel", PSEL, 1);
      check_val("setup_pen", PENABLE, 0);
      check_val("setup_addr", PADDR, a);
      check_val("setup_pwrite", PWRITE, is_write);
      if (is_write) check_val("setup_pwdata", PWDATA, data);

      // ACCESS, waits cycles with PREADY low
      for (int i = 0; i <= waits; i++) begin
         cyc();
         PREADY   = (i == waits);
         PSLVERR  = err && (i == waits);
         PRDATA   = (i == waits) ? slave_mem[PADDR] : 8'($urandom);
         RX_VALID = drop && (i == 0);
         RX_DATA  = 8'($urandom);
         @(negedge PCLK);
         check_val("acc_psel", PSEL, 1);
         check_val("acc_pen", PENABLE, 1);
         check_val("acc_addr", PADDR, a);
         check_val("acc_pwrite", PWRITE, is_write);
         check_val("acc_drop", RX_DROP, drop && (i == 0));
         if (i == waits && PWRITE && !err) slave_mem[PADDR] = PWDATA;
      end
      cyc();
      PREADY   = 1'b0;
      PSLVERR  = 1'b0;
      RX_VALID = 1'b0;
      #0;
      take_resp_first(exp_rsp, hold);
      frame_no++;
      $display("frame %0d %s addr=%02h data=%02h waits=%0d err=%0d hold=%0d resp=%02h",
               frame_no, is_write ? "write" : "read ", a, data, waits, err, hold, exp_rsp);
   endtask

   // Response phase whose first cycle has already been started by the caller.
   task automatic take_resp_first(input logic [7:0] exp, input int hold);
      TX_READY = (hold == 0);
      @(negedge PCLK);
      check_val("rsp_txv", TX_VALID, 1);
      check_val("rsp_txd", TX_DATA, exp);
      check_val("rsp_psel", PSEL, 0);
      check_val("rsp_pen", PENABLE, 0);
      if (hold > 0) take_resp(exp, hold - 1, "rsp");
      else begin
         cyc();
         TX_READY = 1'b0;
         @(negedge PCLK);
         check_val("rsp_txv_done", TX_VALID, 0);
         check_val("rsp_busy_done", BUSY, 0);
      end
   endtask

   // Unknown command byte: immediate error response, no APB activity.
   task automatic do_bad(input logic [7:0] cmd, input int hold, input bit drop);
      send_byte(cmd, 0);
      cyc();
      RX_VALID = drop;
      RX_DATA  = 8'($urandom);
      TX_READY = (hold == 0);
      @(negedge PCLK);
      check_val("bad_txv", TX_VALID, 1);
      check_val("bad_txd", TX_DATA, 8'h45);
      check_val("bad_psel", PSEL, 0);
      check_val("bad_drop", RX_DROP, drop);
      if (hold > 0) take_resp(8'h45, hold - 1, "bad");
      else begin
         cyc();
         RX_VALID = 1'b0;
         TX_READY = 1'b0;
         @(negedge PCLK);
         check_val("bad_txv_done", TX_VALID, 0);
         check_val("bad_busy_done", BUSY, 0);
      end
      frame_no++;
      $display("frame %0d badcmd cmd=%02h hold=%0d resp=45", frame_no, cmd, hold);
   endtask

   // Abandoned frame: after the last byte the block stays busy for exactly
   // TIMEOUT cycles, then goes idle with no bus cycle and no response.
   task automatic do_timeout(input bit with_addr, input logic [7:0] addr);
      send_byte(8'h57, 0);
      if (with_addr) send_byte(addr, 0);
      for (int k = 0; k < TIMEOUT; k++) begin
         cyc();
         RX_VALID = 1'b0;
         @(negedge PCLK);
         check_val("to_busy", BUSY, 1);
         check_val("to_psel", PSEL, 0);
         check_val("to_txv", TX_VALID, 0);
      end
      cyc();
      @(negedge PCLK);
      check_val("to_idle", BUSY, 0);
      check_val("to_txv_end", TX_VALID, 0);
      frame_no++;
      $display("frame %0d timeout after %s", frame_no, with_addr ? "addr" : "cmd");
   endtask

   initial begin
      logic [7:0] bad;
      int         kind;

      for (int m = 0; m < 32; m++) begin
         ref_mem[m]   = 8'($urandom);
         slave_mem[m] = ref_mem[m];
      end
      PRESETN  = 1'b0;
      RX_DATA  = 8'h00;
      RX_VALID = 1'b0;
      TX_READY = 1'b0;
      PRDATA   = 8'h00;
      PREADY   = 1'b0;
      PSLVERR  = 1'b0;
      repeat (3) @(negedge PCLK);

      check_val("rst_txv", TX_VALID, 0);
      check_val("rst_txd", TX_DATA, 0);
      check_val("rst_psel", PSEL, 0);
      check_val("rst_pen", PENABLE, 0);
      check_val("rst_pwrite", PWRITE, 0);
      check_val("rst_paddr", PADDR, 0);
      check_val("rst_pwdata", PWDATA, 0);
      check_val("rst_drop", RX_DROP, 0);
      check_val("rst_busy", BUSY, 0);
      PRESETN = 1'b1;

      // Directed cases from the plan
      do_frame(1'b1, 8'h04, 8'hA5, 0, 1'b0, 0, 1'b0, 0);
      do_frame(1'b0, 8'h10, 8'h00, 2, 1'b0, 0, 1'b0, 0);
      do_frame(1'b0, 8'h07, 8'h00, 0, 1'b1, 0, 1'b0, 0);
      do_bad(8'h41, 0, 1'b0);
      do_timeout(1'b1, 8'h02);
      do_frame(1'b0, 8'h04, 8'h00, 0, 1'b0, 0, 1'b0, 0);
      do_frame(1'b1, 8'hE3, 8'h5A, 1, 1'b0, 5, 1'b1, 0);
      do_frame(1'b1, 8'h09, 8'h11, 0, 1'b0, 0, 1'b0, TIMEOUT - 1);
      do_bad(8'h00, 2, 1'b1);

      // Reset during ACCESS: outputs must fall before the next clock edge
      send_byte(8'h57, 0);
      send_byte(8'h06, 0);
      send_byte(8'hC3, 0);
      cyc();
      RX_VALID = 1'b0;
      PREADY   = 1'b0;
      cyc();
      @(negedge PCLK);
      check_val("mid_pen_before", PENABLE, 1);
      @(posedge PCLK);
      #2;
      PRESETN = 1'b0;
      #1;
      check_val("mid_psel", PSEL, 0);
      check_val("mid_pen", PENABLE, 0);
      check_val("mid_txv", TX_VALID, 0);
      check_val("mid_busy", BUSY, 0);
      @(negedge PCLK);
      @(negedge PCLK);
      PRESETN = 1'b1;
      cyc();
      @(negedge PCLK);
      check_val("mid_txv_after", TX_VALID, 0);
      check_val("mid_busy_after", BUSY, 0);
      $display("frame %0d reset during access", frame_no);
      do_frame(1'b1, 8'h06, 8'h3E, 0, 1'b0, 0, 1'b0, 0);
      do_frame(1'b0, 8'h06, 8'h00, 0, 1'b0, 0, 1'b0, 0);

      // Randomized frames
      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 4) begin
            do_frame(1'b1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 4) == 0), int'($urandom_range(0, 5)),
                     $urandom_range(0, 2) == 0, int'($urandom_range(0, TIMEOUT - 1)));
         end else if (kind < 8) begin
            do_frame(1'b0, 8'($urandom), 8'h00, int'($urandom_range(0, 3)),
                     ($urandom_range(0, 4) == 0), int'($urandom_range(0, 5)),
                     $urandom_range(0, 2) == 0, int'($urandom_range(0, TIMEOUT - 1)));
         end else if (kind == 8) begin
            bad = 8'($urandom);
            if (bad == 8'h57 || bad == 8'h52) bad = 8'h3F;
            do_bad(bad, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
         end else begin
            do_timeout($urandom_range(0, 1) == 1, 8'($urandom));
         end
      end

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule
